// File: rtl/q_select_db.sv
// Difficulty-filtered question picker: scans from an LFSR-chosen start, skipping recently served entries on the first pass.
// Latency 2..2*DEPTH+1 cycles from REQ to VALID/ERR; REQ and table writes are ignored while BUSY (no queueing).
module q_select_db #(
    parameter int          ENTRY_W = 24,
    parameter int          ADDR_W  = 4,
    parameter int          DIFF_W  = 2,
    parameter int          HIST    = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [ADDR_W-1:0]  WR_ADDR,
    input  logic [ENTRY_W-1:0] WR_DATA,
    input  logic               REQ,
    input  logic [DIFF_W-1:0]  DIFF_SEL,
    output logic [ENTRY_W-1:0] QUESTION,
    output logic [ADDR_W-1:0]  Q_INDEX,
    output logic               VALID,
    output logic               ERR,
    output logic               BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH1,
        S_SEARCH2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [DIFF_W-1:0]   diff_q, diff_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   hist_q [HIST];
    logic [ADDR_W-1:0]   hist_d [HIST];
    logic [ENTRY_W-1:0]  question_q, question_d;
    logic [ADDR_W-1:0]   q_index_q, q_index_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic                mem_we;

    logic [ENTRY_W-1:0]  cur_entry;
    logic [DIFF_W-1:0]   cur_diff;
    logic                in_hist;
    logic                hit;
    logic                last;

    assign cur_entry = mem_q[ptr_q];
    assign cur_diff  = cur_entry[ENTRY_W-1 -: DIFF_W];
    assign last      = (count_q == {ADDR_W{1'b1}});

    // Fibonacci taps 16,14,13,11
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        in_hist = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            if (hist_q[i] == ptr_q) begin
                in_hist = 1'b1;
            end
        end
    end

    // Index 0 is the null entry; the history filter only applies on the first pass.
    assign hit = (ptr_q != '0) && (cur_diff == diff_q)
                 && ((state_q == S_SEARCH2) || !in_hist);

    always_comb begin
        state_d    = state_q;
        diff_d     = diff_q;
        start_d    = start_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        hist_d     = hist_q;
        question_d = question_q;
        q_index_d  = q_index_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_we = WR_EN;
                if (REQ) begin
                    diff_d  = DIFF_SEL;
                    start_d = lfsr_q[ADDR_W-1:0];
                    ptr_d   = lfsr_q[ADDR_W-1:0];
                    count_d = '0;
                    state_d = S_SEARCH1;
                end
            end
            S_SEARCH1, S_SEARCH2: begin
                if (hit) begin
                    question_d = cur_entry;
                    q_index_d  = ptr_q;
                    valid_d    = 1'b1;
                    hist_d[0]  = ptr_q;
                    for (int i = 1; i < HIST; i++) begin
                        hist_d[i] = hist_q[i-1];
                    end
                    state_d = S_IDLE;
                end else if (last) begin
                    if (state_q == S_SEARCH1) begin
                        ptr_d   = start_q;
                        count_d = '0;
                        state_d = S_SEARCH2;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            diff_q     <= '0;
            start_q    <= '0;
            ptr_q      <= '0;
            count_q    <= '0;
            hist_q     <= '{default: '0};
            question_q <= '0;
            q_index_q  <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            diff_q     <= diff_d;
            start_q    <= start_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            hist_q     <= hist_d;
            question_q <= question_d;
            q_index_q  <= q_index_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    // Table contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[WR_ADDR] <= WR_DATA;
        end
    end

    assign QUESTION = question_q;
    assign Q_INDEX  = q_index_q;
    assign VALID    = valid_q;
    assign ERR      = err_q;
    assign BUSY     = (state_q != S_IDLE);

endmodule

// File: tb/tb_q_select_db.sv
// Directed bench for q_select_db: table-driven single-match vectors plus multi-cycle corner sequences.
module tb_q_select_db;

    localparam int          ENTRY_W = 24;
    localparam int          ADDR_W  = 4;
    localparam int          DIFF_W  = 2;
    localparam int          HIST    = 4;
    localparam int          DEPTH   = 16;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               WR_EN = 1'b0;
    logic [ADDR_W-1:0]  WR_ADDR = '0;
    logic [ENTRY_W-1:0] WR_DATA = '0;
    logic               REQ = 1'b0;
    logic [DIFF_W-1:0]  DIFF_SEL = '0;
    logic [ENTRY_W-1:0] QUESTION;
    logic [ADDR_W-1:0]  Q_INDEX;
    logic               VALID;
    logic               ERR;
    logic               BUSY;

    q_select_db #(
        .ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W), .DIFF_W(DIFF_W), .HIST(HIST), .SEED(SEED)
    ) dut (
        .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
        .REQ(REQ), .DIFF_SEL(DIFF_SEL), .QUESTION(QUESTION), .Q_INDEX(Q_INDEX),
        .VALID(VALID), .ERR(ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          idx;
        logic [23:0] data;
        logic [1:0]  dsel;
        bit          exp_valid;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          resp_cnt = 0;
    int          strobe_bad = 0;
    bit          prev_resp = 1'b0;
    logic [23:0] m_mem [DEPTH];
    int          m_hist [HIST];
    logic [15:0] m_lfsr;
    logic [3:0]  req_start;
    logic [23:0] last_q = '0;
    vec_t        vecs [5];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge CLK) m_lfsr <= RST ? SEED : lfsr_step(m_lfsr);

    always @(negedge CLK) begin
        if ((VALID && ERR) || ((VALID || ERR) && prev_resp)) strobe_bad <= strobe_bad + 1;
        if (VALID || ERR) resp_cnt <= resp_cnt + 1;
        prev_resp <= VALID || ERR;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input int idx, input logic [23:0] d);
        WR_EN = 1'b1;
        WR_ADDR = idx[3:0];
        WR_DATA = d;
        tick();
        WR_EN = 1'b0;
        m_mem[idx] = d;
    endtask

    task automatic fill_bg();
        for (int i = 0; i < DEPTH; i++) wr(i, {2'b11, 22'(i * 131)});
    endtask

    function automatic bit in_mhist(input int p);
        bit f = 1'b0;
        for (int i = 0; i < HIST; i++) if (m_hist[i] == p) f = 1'b1;
        return f;
    endfunction

    task automatic push_hist(input int p);
        for (int i = HIST - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = p;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < HIST; i++) m_hist[i] = 0;
    endtask

    // Reference picker: expected outcome and response cycle offset from the REQ edge.
    task automatic model_pick(input logic [3:0] st, input logic [1:0] d,
                              output bit ev, output int eidx, output int elat);
        ev = 1'b0;
        eidx = -1;
        elat = 2 * DEPTH + 1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < DEPTH; k++) begin
                int p;
                p = (int'(st) + k) % DEPTH;
                if (!ev && p != 0 && m_mem[p][23:22] == d && (pass == 1 || !in_mhist(p))) begin
                    ev = 1'b1;
                    eidx = p;
                    elat = pass * DEPTH + k + 2;
                end
            end
        end
    endtask

    task automatic do_req(input logic [1:0] d);
        REQ = 1'b1;
        DIFF_SEL = d;
        req_start = m_lfsr[3:0];
        tick();
        REQ = 1'b0;
    endtask

    task automatic wait_resp(input int lat0, output bit gv, output bit ge, output int lat);
        bit done;
        done = 1'b0;
        lat = lat0;
        gv = 1'b0;
        ge = 1'b0;
        while (!done && lat < 40) begin
            if (VALID || ERR) begin
                gv = VALID;
                ge = ERR;
                done = 1'b1;
            end else begin
                tick();
                lat++;
            end
        end
    endtask

    task automatic check_resp(input string tag, input bit gv, input bit ge, input int lat,
                              input bit ev, input int eidx, input int elat);
        chk({tag, "_valid"}, gv, ev);
        chk({tag, "_err"}, ge, !ev);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy"}, BUSY, 0);
        if (ev) begin
            chk({tag, "_idx"}, Q_INDEX, eidx);
            chk({tag, "_q"}, QUESTION, m_mem[eidx]);
            push_hist(eidx);
            last_q = m_mem[eidx];
        end else begin
            chk({tag, "_q_hold"}, QUESTION, last_q);
        end
    endtask

    task automatic run_req(input string tag, input logic [1:0] d, output int got_idx, output int got_lat);
        bit gv, ge, ev;
        int eidx, elat;
        do_req(d);
        model_pick(req_start, d, ev, eidx, elat);
        wait_resp(1, gv, ge, got_lat);
        got_idx = gv ? int'(Q_INDEX) : -1;
        check_resp(tag, gv, ge, got_lat, ev, eidx, elat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx, lat, i0, i1, snap;
        bit  gv, ge, ev;
        int  eidx, elat;

        vecs[0] = '{5,  24'h427124, 2'b01, 1'b1};
        vecs[1] = '{1,  24'h012345, 2'b00, 1'b1};
        vecs[2] = '{15, 24'h8ABCDE, 2'b10, 1'b1};
        vecs[3] = '{8,  24'h0F0F0F, 2'b00, 1'b1};
        vecs[4] = '{0,  24'h400000, 2'b01, 1'b0};
        clear_hist();

        // Reset state and LFSR sequence
        repeat (3) tick();
        chk("rst_lfsr_held", dut.lfsr_q, SEED);
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("idle_lfsr", dut.lfsr_q, m_lfsr);
        end
        chk("idle_lfsr_moved", m_lfsr != SEED, 1);
        chk("rst_question", QUESTION, 0);
        chk("rst_qindex", Q_INDEX, 0);
        chk("rst_valid", VALID, 0);
        chk("rst_err", ERR, 0);
        chk("rst_busy", BUSY, 0);

        // Single-match table vectors; the last one only matches the null entry
        for (int v = 0; v < 5; v++) begin
            fill_bg();
            wr(vecs[v].idx, vecs[v].data);
            run_req($sformatf("vec%0d", v), vecs[v].dsel, idx, lat);
            chk($sformatf("vec%0d_tbl_idx", v), idx, vecs[v].exp_valid ? vecs[v].idx : -1);
            if (vecs[v].exp_valid) chk($sformatf("vec%0d_lat_bound", v), lat <= DEPTH + 1, 1);
        end

        // Two candidates, three requests: third must fall into the history-free pass
        fill_bg();
        wr(3, 24'h4A0003);
        wr(9, 24'h5B0009);
        run_req("pair0", 2'b01, i0, lat);
        run_req("pair1", 2'b01, i1, lat);
        chk("pair_set", (i0 == 3 && i1 == 9) || (i0 == 9 && i1 == 3), 1);
        run_req("pair2", 2'b01, idx, lat);
        chk("pair2_pass2", lat >= DEPTH + 2, 1);

        // No real entry of the requested difficulty
        fill_bg();
        wr(0, 24'h800000);
        run_req("nomatch", 2'b10, idx, lat);
        chk("nomatch_lat33", lat, 2 * DEPTH + 1);

        // Writes and REQ while busy are dropped
        fill_bg();
        wr(6, 24'h000006);
        snap = resp_cnt;
        do_req(2'b00);
        model_pick(req_start, 2'b00, ev, eidx, elat);
        chk("busy_flag", BUSY, 1);
        WR_EN = 1'b1;
        WR_ADDR = 4'd6;
        WR_DATA = 24'hC00006;
        REQ = 1'b1;
        tick();
        WR_EN = 1'b0;
        REQ = 1'b0;
        wait_resp(2, gv, ge, lat);
        check_resp("busy", gv, ge, lat, ev, eidx, elat);
        repeat (40) tick();
        chk("busy_one_resp", resp_cnt - snap, 1);
        run_req("busy_after", 2'b00, idx, lat);
        chk("busy_after_idx6", idx, 6);

        // Reset in the 4th SEARCH1 cycle aborts silently and clears history
        fill_bg();
        wr(0, 24'h800000);
        snap = resp_cnt;
        do_req(2'b10);
        tick();
        tick();
        tick();
        chk("mid_busy_before", BUSY, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        clear_hist();
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_valid", VALID, 0);
        chk("mid_rst_err", ERR, 0);
        repeat (40) tick();
        chk("mid_rst_no_resp", resp_cnt - snap, 0);
        wr(6, 24'h000006);
        run_req("post_rst", 2'b00, idx, lat);
        chk("post_rst_pass1", lat <= DEPTH + 1, 1);

        tick();
        chk("strobe_rule", strobe_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
